mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single cache-line memory bus (`mem_address` / `mem_data` / `mem_command`) between two line-level requesters, e.g. separate instruction and data caches in front of `mem`. It arbitrates round-robin and sequences each whole-line transaction: command issue, write burst, bus release, response wait and read burst. Requesters see a split-direction handshake, and the memory side keeps the existing bidirectional bus protocol.

## Interface
- `MEM_ADDR_SIZE`, 19, byte address width
- `BUS_SIZE`, 16, data bus width
- `CACHE_OFFSET_SIZE`, 4, line offset bits; line address width `AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE`
- `CACHE_LINE_SIZE`, 16, line bytes; beats per line `NB = CACHE_LINE_SIZE*8/BUS_SIZE` (8)

Ports:
- `clk`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request, held until `done`
- `req_write`  in  2  1 = WRITE_LINE, 0 = READ_LINE; stable while `req_valid`
- `req0_addr`, `req1_addr`  in  AW  line address
- `req0_wdata`, `req1_wdata`  in  BUS_SIZE  current write beat
- `grant`  out  2  one-hot owner, held for the whole transaction
- `beat`  out  2  one-hot beat strobe: write beat consumed / read beat valid on `rdata`
- `rdata`  out  BUS_SIZE  registered read beat
- `done`  out  2  one-cycle end-of-transaction pulse
- `mem_address`  out  AW  line address to memory
- `mem_data`  inout  BUS_SIZE  memory data bus
- `mem_command`  inout  2  C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3

## Operation
- States:
  - IDLE: drives C2_NOP, `mem_data` = z. Picks a winner among `req_valid` (round-robin; the pointer favours the requester not granted last). On a valid pick, goes to ISSUE for a read or WBURST for a write.
  - ISSUE: drives C2_READ_LINE + address for 1 cycle, then WAIT_RSP.
  - WBURST: drives C2_WRITE_LINE, address, `mem_data` = granted `reqN_wdata`. Asserts `beat` every cycle. After NB cycles, goes to WAIT_RSP.
  - WAIT_RSP: releases `mem_command` and `mem_data` (z).
    - Write: on sampling C2_RESPONSE, goes to DONE.
    - Read: the first sampled C2_RESPONSE is beat 0; goes to RBURST.
  - RBURST: released. Samples `mem_data` each cycle `mem_command` == C2_RESPONSE and counts beats with a wrapping counter of width log2(NB). After beat NB−1 is sampled, goes to DONE.
  - DONE: drives C2_NOP, pulses `done`, then IDLE. The round-robin pointer updates here.
- `grant` is asserted from ISSUE/WBURST through DONE inclusive.
- Non-preemptive. Arbitration happens only in IDLE.
- Requester dropping `req_valid` mid-transaction: ignored; the transaction completes and its strobes are still issued.
- C2_RESPONSE seen in IDLE/ISSUE/WBURST: ignored.
- `mem_address` holds the last issued address when not driving it.
- Reset (asserted low) forces IDLE immediately from any state. Outputs during reset:
  - `grant`, `beat`, `done`, `rdata` = 0
  - `mem_address` = 0, `mem_command` = C2_NOP, `mem_data` = z
  - round-robin pointer set so that requester 0 wins the first tie

## Timing
- Request seen in IDLE at edge T → `grant` and the first bus cycle at T+1. There is no combinational grant.
- Write: beats in cycles T+1..T+NB, one `beat` per cycle. The requester advances `reqN_wdata` after each `beat` edge. Bus released at T+NB+1.
- Read: READ_LINE at T+1, released from T+2. Memory must not drive before T+2.
- Read beat sampled at edge E → `rdata` and `beat` valid in cycle E+1. The final beat's strobe coincides with `done`.
- `done` at cycle D → IDLE at D+1. The earliest next grant is at D+2. The back-to-back minimum gap of one IDLE cycle is required.
- Both requesters valid continuously: grants strictly alternate.

## Structure
- Package `mem_bus_pkg`: the C2_* command enum, the state enum, and localparams AW and NB. The package is shared with `cache` and `mem` for the command codes.
- Sub-module `rr_arbiter_2`: 2-way round-robin pick with last-grant pointer update. The pointer updates only on the DONE strobe.
- The beat counter and tri-state drivers live in the top module.

## Test plan
- Single read, req0, addr 0x1234 → READ_LINE + 0x1234 at T+1, `mem_data` z from T+2. Memory beats 0xA000..0xA007 → 8 `beat[0]` strobes with matching `rdata`, `done[0]` with the last beat.
- Single write, req1, addr 0x0042, wdata 0xB000+i → WRITE_LINE for exactly 8 cycles with data 0xB000..0xB007. After RESPONSE, one `done[1]` pulse.
- Both requesters valid from reset, 4 transactions each → grants order 0,1,0,1…; no overlap; `grant` never two-hot.
- Memory delays RESPONSE 20 cycles and inserts 2 NOP cycles between read beats → the arbiter waits; exactly 8 beats counted; `rdata` is correct.
- Reset pulsed low mid-WBURST (beat 3) → same-cycle `grant` = 0, `mem_command` = NOP, state IDLE. After release, req0 is granted first.
- Stray C2_RESPONSE in IDLE, and `req_valid[0]` dropped mid-read → no `beat`/`done` for the stray response; the read still completes with 8 strobes and `done[0]`.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cache-line memory bus: command codes, arbiter states
// and derived line geometry.
package mem_bus_pkg;

    localparam int MEM_ADDR_SIZE     = 19;
    localparam int BUS_SIZE          = 16;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int CACHE_LINE_SIZE   = 16;
    localparam int AW                = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int NB                = CACHE_LINE_SIZE * 8 / BUS_SIZE;
    localparam int CW                = $clog2(NB);

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WBURST,
        S_WAIT_RSP,
        S_RBURST,
        S_DONE
    } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake of the line bus arbiter: two requesters in, strobes out.
interface mem_bus_arbiter_if;
    import mem_bus_pkg::*;

    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [AW-1:0]       req0_addr;
    logic [AW-1:0]       req1_addr;
    logic [BUS_SIZE-1:0] req0_wdata;
    logic [BUS_SIZE-1:0] req1_wdata;
    logic [1:0]          grant;
    logic [1:0]          beat;
    logic [BUS_SIZE-1:0] rdata;
    logic [1:0]          done;

    modport master (
        output req_valid, req_write, req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  grant, beat, rdata, done
    );

    modport slave (
        input  req_valid, req_write, req0_addr, req1_addr, req0_wdata, req1_wdata,
        output grant, beat, rdata, done
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick; the tie-break pointer moves only when a transaction
// finishes, favouring the requester that was not just served.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic [1:0] owner_i,
    output logic [1:0] pick_o
);

    logic prio_q, prio_d;  // 1: requester 1 wins a tie

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        prio_d = prio_q;
        pick_o = 2'b00;
        if (update_i) begin
            prio_d = owner_i[0];
        end
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = prio_q ? 2'b10 : 2'b01;
            default: pick_o = 2'b00;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the bidirectional cache-line memory bus between two requesters and
// sequences each whole-line read or write transaction.
module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    mem_bus_arbiter_if.slave    bus,
    output logic [AW-1:0]       mem_address,
    inout  wire  [BUS_SIZE-1:0] mem_data,
    inout  wire  [1:0]          mem_command
);

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                write_q, write_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BUS_SIZE-1:0] rdata_q, rdata_d;
    logic                rbeat_q, rbeat_d;
    logic [1:0]          pick;
    logic                cmd_oe;
    logic                data_oe;
    cmd_e                cmd_drv;
    logic                rsp_seen;

    rr_arbiter_2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (bus.req_valid),
        .update_i (state_q == S_DONE),
        .owner_i  (owner_q),
        .pick_o   (pick)
    );

    assign rsp_seen = (mem_command == C2_RESPONSE);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rbeat_d = 1'b0;
        cmd_oe  = 1'b0;
        cmd_drv = C2_NOP;
        data_oe = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_oe = 1'b1;
                if (pick != 2'b00) begin
                    owner_d = pick;
                    write_d = |(pick & bus.req_write);
                    addr_d  = pick[1] ? bus.req1_addr : bus.req0_addr;
                    cnt_d   = '0;
                    state_d = write_d ? S_WBURST : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_oe  = 1'b1;
                cmd_drv = C2_READ_LINE;
                state_d = S_WAIT_RSP;
            end
            S_WBURST: begin
                cmd_oe  = 1'b1;
                cmd_drv = C2_WRITE_LINE;
                data_oe = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NB - 1)) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_seen) begin
                    if (write_q) begin
                        state_d = S_DONE;
                    end else begin
                        // The first response of a read already carries beat 0.
                        rdata_d = mem_data;
                        rbeat_d = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_RBURST;
                    end
                end
            end
            S_RBURST: begin
                if (rsp_seen) begin
                    rdata_d = mem_data;
                    rbeat_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(NB - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cmd_oe  = 1'b1;
                owner_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 2'b00;
            write_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rbeat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rbeat_q <= rbeat_d;
        end
    end

    assign bus.grant   = owner_q;
    assign bus.beat    = ((state_q == S_WBURST) || rbeat_q) ? owner_q : 2'b00;
    assign bus.done    = (state_q == S_DONE) ? owner_q : 2'b00;
    assign bus.rdata   = rdata_q;
    assign mem_address = addr_q;

    assign mem_command = cmd_oe  ? cmd_drv : 2'bzz;
    assign mem_data    = data_oe ? (owner_q[1] ? bus.req1_wdata : bus.req0_wdata)
                                 : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of single transactions plus
// hand-written sequences for alternation, stray responses and mid-burst reset.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    typedef struct {
        logic [1:0]          who;
        logic [BUS_SIZE-1:0] data;
    } exp_t;

    typedef struct {
        int                  who;
        bit                  write;
        logic [AW-1:0]       addr;
        logic [BUS_SIZE-1:0] base;
        int                  delay;
        int                  gap;
        bit                  drop;
        logic [1:0]          exp_grant;
        logic [1:0]          exp_cmd;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if rq_if ();

    logic [AW-1:0]       mem_address;
    wire  [BUS_SIZE-1:0] mem_data;
    wire  [1:0]          mem_command;

    logic                mem_cmd_oe  = 1'b0;
    logic [1:0]          mem_cmd_val = 2'b00;
    logic                mem_dat_oe  = 1'b0;
    logic [BUS_SIZE-1:0] mem_dat_val = '0;

    assign mem_command = mem_cmd_oe ? mem_cmd_val : 2'bzz;
    assign mem_data    = mem_dat_oe ? mem_dat_val : {BUS_SIZE{1'bz}};

    mem_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (rq_if),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_command (mem_command)
    );

    int   checks     = 0;
    int   errors     = 0;
    int   beat_total = 0;
    int   twohot     = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int who, input bit wr, input logic [AW-1:0] a,
                                input logic [BUS_SIZE-1:0] base, input int dly,
                                input int gap, input bit drop);
        vec_t v;
        v.who       = who;
        v.write     = wr;
        v.addr      = a;
        v.base      = base;
        v.delay     = dly;
        v.gap       = gap;
        v.drop      = drop;
        v.exp_grant = (who == 1) ? 2'b10 : 2'b01;
        v.exp_cmd   = wr ? 2'd3 : 2'd2;
        return v;
    endfunction

    // Beat scoreboard: every strobe pops the next expected owner/data pair.
    always @(negedge clk) begin
        if (reset) begin
            if (rq_if.grant == 2'b11) twohot++;
            if (rq_if.beat != 2'b00) begin
                beat_total++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", {30'd0, rq_if.beat}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_owner", {30'd0, rq_if.beat}, {30'd0, mon_e.who});
                    check("beat_data",
                          (mem_command == C2_WRITE_LINE) ? {16'd0, mem_data} : {16'd0, rq_if.rdata},
                          {16'd0, mon_e.data});
                end
            end
        end
    end

    task automatic set_req(input int who, input bit wr, input logic [AW-1:0] a,
                           input logic [BUS_SIZE-1:0] wd);
        if (who == 1) begin
            rq_if.req1_addr  = a;
            rq_if.req1_wdata = wd;
        end else begin
            rq_if.req0_addr  = a;
            rq_if.req0_wdata = wd;
        end
        rq_if.req_write[who] = wr;
        rq_if.req_valid[who] = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        logic [1:0]          onehot;
        logic [BUS_SIZE-1:0] d;
        int                  wr_cycles;
        int                  beats_before;
        onehot       = v.exp_grant;
        wr_cycles    = 0;
        beats_before = beat_total;
        set_req(v.who, v.write, v.addr, v.base);
        if (v.write) begin
            for (int i = 0; i < NB; i++) exp_q.push_back('{onehot, v.base + BUS_SIZE'(i)});
        end
        tick();
        check("first_grant", {30'd0, rq_if.grant}, {30'd0, v.exp_grant});
        check("first_cmd", {30'd0, mem_command}, {30'd0, v.exp_cmd});
        check("first_addr", {17'd0, mem_address}, {17'd0, v.addr});
        if (v.write) begin
            for (int i = 0; i < NB; i++) begin
                d = v.base + BUS_SIZE'(i);
                if (v.who == 1) rq_if.req1_wdata = d; else rq_if.req0_wdata = d;
                if (mem_command == C2_WRITE_LINE) wr_cycles++;
                tick();
            end
            check("wr_cycles", wr_cycles, NB);
            check("wr_cmd_released", {30'd0, mem_command}, 32'd0);
            check("wr_no_done_early", {30'd0, rq_if.done}, 32'd0);
            repeat (v.delay) tick();
            mem_cmd_oe  = 1'b1;
            mem_cmd_val = C2_RESPONSE;
            tick();
            mem_cmd_oe  = 1'b0;
            check("wr_done", {30'd0, rq_if.done}, {30'd0, onehot});
        end else begin
            tick();
            check("rd_cmd_released", {30'd0, mem_command}, 32'd0);
            check("rd_data_released", {16'd0, mem_data}, 32'd0);
            repeat (v.delay) tick();
            for (int b = 0; b < NB; b++) begin
                d           = v.base + BUS_SIZE'(b);
                mem_cmd_oe  = 1'b1;
                mem_cmd_val = C2_RESPONSE;
                mem_dat_oe  = 1'b1;
                mem_dat_val = d;
                exp_q.push_back('{onehot, d});
                if (v.drop && b == 3) rq_if.req_valid[v.who] = 1'b0;
                tick();
                mem_dat_oe  = 1'b0;
                mem_cmd_val = C2_NOP;
                if (b < NB - 1) begin
                    repeat (v.gap) tick();
                end
                mem_cmd_oe = 1'b0;
            end
            check("rd_done", {30'd0, rq_if.done}, {30'd0, onehot});
            check("rd_last_beat", {30'd0, rq_if.beat}, {30'd0, onehot});
            check("rd_last_rdata", {16'd0, rq_if.rdata}, {16'd0, v.base + BUS_SIZE'(NB - 1)});
        end
        rq_if.req_valid[v.who] = 1'b0;
        tick();
        check("done_one_cycle", {30'd0, rq_if.done}, 32'd0);
        check("grant_released", {30'd0, rq_if.grant}, 32'd0);
        check("beat_count", beat_total - beats_before, NB);
    endtask

    // Both requesters keep reading; memory answers every READ_LINE a cycle later.
    task automatic run_alternation();
        int         order_idx  = 0;
        int         dones0     = 0;
        int         dones1     = 0;
        int         pend       = 0;
        int         txn        = 0;
        bit         after_done = 1'b0;
        logic [1:0] prev_grant = 2'b00;
        logic [1:0] cmd_seen;
        logic [BUS_SIZE-1:0] d;
        for (int cyc = 0; cyc < 600 && (dones0 + dones1) < 8; cyc++) begin
            tick();
            cmd_seen = mem_command;
            if (rq_if.grant != 2'b00 && prev_grant == 2'b00) begin
                check("alt_order", {30'd0, rq_if.grant}, (order_idx % 2 == 0) ? 32'd1 : 32'd2);
                order_idx++;
            end
            if (after_done) begin
                check("alt_idle_gap", {30'd0, rq_if.grant}, 32'd0);
                after_done = 1'b0;
            end
            prev_grant = rq_if.grant;
            mem_cmd_oe = 1'b0;
            mem_dat_oe = 1'b0;
            if (pend > 0) begin
                d           = 16'h5000 + BUS_SIZE'(txn * 16 + (NB - pend));
                mem_cmd_oe  = 1'b1;
                mem_cmd_val = C2_RESPONSE;
                mem_dat_oe  = 1'b1;
                mem_dat_val = d;
                exp_q.push_back('{rq_if.grant, d});
                pend--;
                if (pend == 0) txn++;
            end
            if (cmd_seen == C2_READ_LINE) pend = NB;
            if (rq_if.done != 2'b00) begin
                after_done = 1'b1;
                if (rq_if.done[0]) dones0++; else dones1++;
                if (dones0 == 4) rq_if.req_valid[0] = 1'b0;
                if (dones1 == 4) rq_if.req_valid[1] = 1'b0;
            end
        end
        mem_cmd_oe = 1'b0;
        mem_dat_oe = 1'b0;
        check("alt_done_count", dones0 + dones1, 8);
        check("alt_grant_count", order_idx, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rq_if.req_valid  = 2'b00;
        rq_if.req_write  = 2'b00;
        rq_if.req0_addr  = '0;
        rq_if.req1_addr  = '0;
        rq_if.req0_wdata = '0;
        rq_if.req1_wdata = '0;

        vecs[0] = mk(0, 1'b0, 15'h1234, 16'hA000, 0, 0, 1'b0);
        vecs[1] = mk(1, 1'b1, 15'h0042, 16'hB000, 0, 0, 1'b0);
        vecs[2] = mk(0, 1'b0, 15'h7FFF, 16'hC000, 20, 2, 1'b0);
        vecs[3] = mk(1, 1'b0, 15'h0001, 16'hD000, 1, 1, 1'b0);
        vecs[4] = mk(0, 1'b1, 15'h4000, 16'hE000, 3, 0, 1'b0);

        // Outputs held in reset.
        tick();
        tick();
        check("rst_grant", {30'd0, rq_if.grant}, 32'd0);
        check("rst_beat", {30'd0, rq_if.beat}, 32'd0);
        check("rst_done", {30'd0, rq_if.done}, 32'd0);
        check("rst_rdata", {16'd0, rq_if.rdata}, 32'd0);
        check("rst_addr", {17'd0, mem_address}, 32'd0);
        check("rst_cmd", {30'd0, mem_command}, 32'd0);
        check("rst_data_released", {16'd0, mem_data}, 32'd0);

        // Both requesters valid from reset release.
        rq_if.req0_addr = 15'h0100;
        rq_if.req1_addr = 15'h0200;
        rq_if.req_valid = 2'b11;
        reset = 1'b1;
        run_alternation();
        tick();

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Stray responses while idle must be ignored.
        mem_cmd_oe  = 1'b1;
        mem_cmd_val = C2_RESPONSE;
        mem_dat_oe  = 1'b1;
        mem_dat_val = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stray_beat", {30'd0, rq_if.beat}, 32'd0);
            check("stray_done", {30'd0, rq_if.done}, 32'd0);
            check("stray_grant", {30'd0, rq_if.grant}, 32'd0);
        end
        mem_cmd_oe = 1'b0;
        mem_dat_oe = 1'b0;
        tick();
        check("stray_beat_after", {30'd0, rq_if.beat}, 32'd0);

        // Read whose requester drops req_valid mid-burst still completes.
        run_txn(mk(0, 1'b0, 15'h0ABC, 16'h9000, 2, 0, 1'b1));
        check("sb_empty", exp_q.size(), 0);

        // Reset during beat 3 of a req1 write; tie pointer currently favours req1.
        set_req(1, 1'b1, 15'h0555, 16'hF000);
        for (int i = 0; i < NB; i++) exp_q.push_back('{2'b10, 16'hF000 + BUS_SIZE'(i)});
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            rq_if.req1_wdata = 16'hF000 + BUS_SIZE'(i);
        end
        check("wb3_grant", {30'd0, rq_if.grant}, 32'd2);
        check("wb3_beat", {30'd0, rq_if.beat}, 32'd2);
        #2 reset = 1'b0;
        #1;
        check("midrst_grant", {30'd0, rq_if.grant}, 32'd0);
        check("midrst_beat", {30'd0, rq_if.beat}, 32'd0);
        check("midrst_cmd", {30'd0, mem_command}, 32'd0);
        check("midrst_data_released", {16'd0, mem_data}, 32'd0);
        exp_q.delete();
        rq_if.req0_addr = 15'h0777;
        rq_if.req_write = 2'b10;
        rq_if.req_valid = 2'b11;
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_grant", {30'd0, rq_if.grant}, 32'd1);
        check("post_rst_cmd", {30'd0, mem_command}, 32'd2);
        check("post_rst_addr", {17'd0, mem_address}, 32'h0777);
        reset = 1'b0;
        rq_if.req_valid = 2'b00;
        #1;

        check("grant_never_two_hot", twohot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
